// File: rtl/uart_encoded_sys_pkg.sv
// Shared definitions for the UART loop-back display system: baud divisors,
// oversampling factor, seven-segment glyphs and FSM state encodings.
package uart_encoded_sys_pkg;

    localparam int OVERSAMPLE = 16;
    localparam int DIV_W      = 14;

    // Glyphs as {a,b,c,d,e,f,g}, active-low
    localparam logic [6:0] GLYPH_0     = 7'b0000001;
    localparam logic [6:0] GLYPH_1     = 7'b1001111;
    localparam logic [6:0] GLYPH_2     = 7'b0010010;
    localparam logic [6:0] GLYPH_3     = 7'b0000110;
    localparam logic [6:0] GLYPH_DASH  = 7'b1111110;
    localparam logic [6:0] GLYPH_BLANK = 7'b1111111;

    typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP} tx_state_t;
    typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP} rx_state_t;

    // Rounded divisor clk_freq / (16 * baud)
    function automatic logic [DIV_W-1:0] baud_div(input logic [2:0] sel, input int clk_freq);
        int baud;
        case (sel)
            3'd0:    baud = 300;
            3'd1:    baud = 1200;
            3'd2:    baud = 4800;
            3'd3:    baud = 9600;
            3'd4:    baud = 19200;
            3'd5:    baud = 38400;
            3'd6:    baud = 57600;
            default: baud = 115200;
        endcase
        baud_div = DIV_W'((clk_freq + baud * (OVERSAMPLE / 2)) / (baud * OVERSAMPLE));
    endfunction

    function automatic logic [6:0] glyph(input logic [1:0] code);
        case (code)
            2'd0:    glyph = GLYPH_0;
            2'd1:    glyph = GLYPH_1;
            2'd2:    glyph = GLYPH_2;
            default: glyph = GLYPH_3;
        endcase
    endfunction

endpackage

// File: rtl/uart_encoded_sys_baud_gen.sv
// 16x oversampling tick generator; restarts on a rate change or on request
// so a new frame always begins on a full tick period.
module uart_baud_gen
    import uart_encoded_sys_pkg::*;
#(
    parameter int CLK_FREQ = 50000000
) (
    input  logic       clk1,
    input  logic       reset,
    input  logic [2:0] baud_select,
    input  logic       restart,
    output logic       tick
);

    logic [DIV_W-1:0] cnt;
    logic [DIV_W-1:0] div;
    logic [2:0]       sel_q;
    logic             changed;

    assign div     = baud_div(baud_select, CLK_FREQ);
    assign changed = (sel_q != baud_select);
    assign tick    = (cnt == div - 1'b1) && !changed;

    always_ff @(posedge clk1) begin
        if (reset) begin
            cnt   <= '0;
            sel_q <= baud_select;
        end else begin
            sel_q <= baud_select;
            if (restart || changed || tick) cnt <= '0;
            else                            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/uart_encoded_sys.sv
// Loop-back UART system: TX FSM drives an internal line into the RX FSM, and
// the received word is shown as four 2-bit codes on a multiplexed display.
module uart_encoded_sys
    import uart_encoded_sys_pkg::*;
#(
    parameter int CLK_FREQ       = 50000000,
    parameter int REFRESH_CYCLES = 50000
) (
    input  logic       clk1,
    input  logic       reset,
    input  logic [2:0] baud_select,
    input  logic       Tx_EN,
    input  logic       Tx_WR,
    input  logic [7:0] Tx_DATA,
    input  logic       Rx_EN,
    output logic       Tx_BUSY,
    output logic       AN0,
    output logic       AN1,
    output logic       AN2,
    output logic       AN3,
    output logic       a,
    output logic       b,
    output logic       c,
    output logic       d,
    output logic       e,
    output logic       f,
    output logic       g,
    output logic       dp
);

    localparam int REF_W = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;

    logic      tick;
    logic      tx_accept;
    logic      tx_line;
    logic      line;

    tx_state_t tx_state, tx_state_n;
    logic [3:0] tx_tcnt, tx_tcnt_n;
    logic [2:0] tx_idx, tx_idx_n;
    logic [7:0] tx_data, tx_data_n;

    rx_state_t rx_state, rx_state_n;
    logic [3:0] rx_tcnt, rx_tcnt_n;
    logic [2:0] rx_idx, rx_idx_n;
    logic [7:0] rx_shift, rx_shift_n;
    logic       rx_par, rx_par_n;
    logic [7:0] disp, disp_n;
    logic       err, err_n;

    logic [REF_W-1:0] ref_cnt;
    logic             ref_wrap;
    logic [1:0]       dig, dig_n;
    logic [3:0]       an;
    logic [6:0]       seg;

    assign tx_accept = Tx_EN && Tx_WR && (tx_state == TX_IDLE);
    assign Tx_BUSY   = (tx_state != TX_IDLE);
    assign line      = tx_line;

    uart_baud_gen #(.CLK_FREQ(CLK_FREQ)) u_baud (
        .clk1        (clk1),
        .reset       (reset),
        .baud_select (baud_select),
        .restart     (tx_accept),
        .tick        (tick)
    );

    always_comb begin
        tx_state_n = tx_state;
        tx_tcnt_n  = tx_tcnt;
        tx_idx_n   = tx_idx;
        tx_data_n  = tx_data;
        tx_line    = 1'b1;
        case (tx_state)
            TX_IDLE: if (tx_accept) begin
                tx_state_n = TX_START;
                tx_data_n  = Tx_DATA;
                tx_tcnt_n  = '0;
                tx_idx_n   = '0;
            end
            TX_START:  tx_line = 1'b0;
            TX_DATA:   tx_line = tx_data[tx_idx];
            TX_PARITY: tx_line = ^tx_data;
            default:   tx_line = 1'b1;
        endcase
        if (tx_state != TX_IDLE && tick) begin
            tx_tcnt_n = tx_tcnt + 1'b1;
            if (tx_tcnt == 4'(OVERSAMPLE - 1)) begin
                case (tx_state)
                    TX_START:  tx_state_n = TX_DATA;
                    TX_DATA:   if (tx_idx == 3'd7) tx_state_n = TX_PARITY;
                               else                tx_idx_n   = tx_idx + 1'b1;
                    TX_PARITY: tx_state_n = TX_STOP;
                    default:   tx_state_n = TX_IDLE;
                endcase
            end
        end
        if (!Tx_EN) tx_state_n = TX_IDLE;
    end

    always_comb begin
        rx_state_n = rx_state;
        rx_tcnt_n  = rx_tcnt;
        rx_idx_n   = rx_idx;
        rx_shift_n = rx_shift;
        rx_par_n   = rx_par;
        disp_n     = disp;
        err_n      = err;
        if (!Rx_EN) begin
            rx_state_n = RX_IDLE;
        end else if (rx_state == RX_IDLE) begin
            if (!line) begin
                rx_state_n = RX_START;
                rx_tcnt_n  = '0;
            end
        end else if (tick) begin
            rx_tcnt_n = rx_tcnt + 1'b1;
            if (rx_state == RX_START) begin
                // Mid-start check rejects glitches; later samples land mid-bit
                if (rx_tcnt == 4'(OVERSAMPLE / 2 - 1)) begin
                    rx_tcnt_n = '0;
                    rx_idx_n  = '0;
                    rx_state_n = line ? RX_IDLE : RX_DATA;
                end
            end else if (rx_tcnt == 4'(OVERSAMPLE - 1)) begin
                case (rx_state)
                    RX_DATA: begin
                        rx_shift_n = {line, rx_shift[7:1]};
                        if (rx_idx == 3'd7) rx_state_n = RX_PARITY;
                        else                rx_idx_n   = rx_idx + 1'b1;
                    end
                    RX_PARITY: begin
                        rx_par_n   = line;
                        rx_state_n = RX_STOP;
                    end
                    default: begin
                        rx_state_n = RX_IDLE;
                        if (line && (rx_par == ^rx_shift)) begin
                            disp_n = rx_shift;
                            err_n  = 1'b0;
                        end else begin
                            err_n  = 1'b1;
                        end
                    end
                endcase
            end
        end
    end

    assign ref_wrap = (ref_cnt == REF_W'(REFRESH_CYCLES - 1));
    assign dig_n    = ref_wrap ? dig + 1'b1 : dig;

    always_ff @(posedge clk1) begin
        if (reset) begin
            tx_state <= TX_IDLE;
            tx_tcnt  <= '0;
            tx_idx   <= '0;
            tx_data  <= '0;
            rx_state <= RX_IDLE;
            rx_tcnt  <= '0;
            rx_idx   <= '0;
            rx_shift <= '0;
            rx_par   <= 1'b0;
            disp     <= 8'h00;
            err      <= 1'b0;
            ref_cnt  <= '0;
            dig      <= '0;
            an       <= 4'hF;
            seg      <= GLYPH_BLANK;
        end else begin
            tx_state <= tx_state_n;
            tx_tcnt  <= tx_tcnt_n;
            tx_idx   <= tx_idx_n;
            tx_data  <= tx_data_n;
            rx_state <= rx_state_n;
            rx_tcnt  <= rx_tcnt_n;
            rx_idx   <= rx_idx_n;
            rx_shift <= rx_shift_n;
            rx_par   <= rx_par_n;
            disp     <= disp_n;
            err      <= err_n;
            ref_cnt  <= ref_wrap ? '0 : ref_cnt + 1'b1;
            dig      <= dig_n;
            an       <= ~(4'b0001 << dig_n);
            seg      <= err ? GLYPH_DASH : glyph(disp[{dig_n, 1'b0} +: 2]);
        end
    end

    assign {AN3, AN2, AN1, AN0}    = an;
    assign {a, b, c, d, e, f, g}   = seg;
    assign dp                      = 1'b1;

endmodule

// File: tb/tb_uart_encoded_sys.sv
// Scoreboard bench for the UART loop-back display: stimulus queues expected
// busy length and digit glyphs, a monitor checks each frame as it completes.
module tb_uart_encoded_sys;

    localparam int R = 8;

    localparam logic [6:0] G0 = 7'b0000001;
    localparam logic [6:0] G1 = 7'b1001111;
    localparam logic [6:0] G2 = 7'b0010010;
    localparam logic [6:0] G3 = 7'b0000110;
    localparam logic [6:0] GD = 7'b1111110;

    logic       clk1 = 1'b0;
    logic       reset;
    logic [2:0] baud_select;
    logic       Tx_EN, Tx_WR, Rx_EN;
    logic [7:0] Tx_DATA;
    logic       Tx_BUSY;
    logic       AN0, AN1, AN2, AN3;
    logic       a, b, c, d, e, f, g, dp;

    typedef struct packed {
        logic [31:0] len;
        logic [27:0] glyphs;   // {AN3, AN2, AN1, AN0}
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;
    int   mon_done = 0;

    always #10 clk1 = ~clk1;

    uart_encoded_sys #(.CLK_FREQ(50000000), .REFRESH_CYCLES(R)) dut (
        .clk1(clk1), .reset(reset), .baud_select(baud_select),
        .Tx_EN(Tx_EN), .Tx_WR(Tx_WR), .Tx_DATA(Tx_DATA), .Rx_EN(Rx_EN),
        .Tx_BUSY(Tx_BUSY), .AN0(AN0), .AN1(AN1), .AN2(AN2), .AN3(AN3),
        .a(a), .b(b), .c(c), .d(d), .e(e), .f(f), .g(g), .dp(dp)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Watch one full refresh cycle and compare each digit's glyph
    task automatic scan(input string tag, input logic [27:0] exp);
        logic [6:0] seen [4];
        logic [3:0] an;
        int bad;
        bad = 0;
        for (int i = 0; i < 4; i++) seen[i] = 7'h7F;
        repeat (4 * R + 4) begin
            @(negedge clk1);
            an = {AN3, AN2, AN1, AN0};
            case (an)
                4'b1110: seen[0] = {a, b, c, d, e, f, g};
                4'b1101: seen[1] = {a, b, c, d, e, f, g};
                4'b1011: seen[2] = {a, b, c, d, e, f, g};
                4'b0111: seen[3] = {a, b, c, d, e, f, g};
                default: bad++;
            endcase
        end
        check($sformatf("%s onehot", tag), bad, 0);
        check($sformatf("%s AN3", tag), {25'd0, seen[3]}, {25'd0, exp[27:21]});
        check($sformatf("%s AN2", tag), {25'd0, seen[2]}, {25'd0, exp[20:14]});
        check($sformatf("%s AN1", tag), {25'd0, seen[1]}, {25'd0, exp[13:7]});
        check($sformatf("%s AN0", tag), {25'd0, seen[0]}, {25'd0, exp[6:0]});
    endtask

    task automatic send(input logic [7:0] data, input logic [27:0] gl, input int len);
        exp_t x;
        x.len    = len;
        x.glyphs = gl;
        @(negedge clk1);
        Tx_DATA = data;
        Tx_WR   = 1'b1;
        sb.push_back(x);
        @(negedge clk1);
        Tx_WR   = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        while (Tx_BUSY && n < budget) begin
            @(negedge clk1);
            n++;
        end
        if (Tx_BUSY) begin
            checks++;
            failures++;
            $display("FAIL busy_timeout: still busy after %0d cycles", budget);
        end
        repeat (60) @(negedge clk1);
    endtask

    initial begin : monitor
        exp_t x;
        int   len;
        forever begin
            @(negedge clk1);
            if (Tx_BUSY) begin
                len = 0;
                while (Tx_BUSY && len < 70000) begin
                    len++;
                    @(negedge clk1);
                end
                if (sb.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_frame: busy for %0d cycles with nothing queued", len);
                end else begin
                    x = sb.pop_front();
                    check($sformatf("frame%0d busy_len", mon_done), len, x.len);
                    scan($sformatf("frame%0d", mon_done), x.glyphs);
                    mon_done++;
                end
            end
        end
    end

    initial begin : stim
        reset = 1'b1; baud_select = 3'b111;
        Tx_EN = 1'b1; Tx_WR = 1'b0; Tx_DATA = 8'h00; Rx_EN = 1'b1;
        repeat (5) @(negedge clk1);
        check("reset busy", {31'd0, Tx_BUSY}, 0);
        check("reset anodes", {28'd0, AN3, AN2, AN1, AN0}, 32'hF);
        check("reset segs", {25'd0, a, b, c, d, e, f, g}, 32'h7F);
        check("reset dp", {31'd0, dp}, 1);
        check("reset line", {31'd0, dut.line}, 1);
        reset = 1'b0;
        scan("post_reset", {G0, G0, G0, G0});

        // 0x94 -> 10 01 01 00
        send(8'h94, {G2, G1, G1, G0}, 4752);
        wait_idle(6000);

        // 0xA1 -> 10 10 00 01, with an extra write mid-frame that must be ignored
        send(8'hA1, {G2, G2, G0, G1}, 4752);
        repeat (1000) @(negedge clk1);
        Tx_DATA = 8'h3C; Tx_WR = 1'b1;
        @(negedge clk1);
        Tx_WR = 1'b0;
        wait_idle(6000);

        // Receiver disabled: display keeps the previous word
        Rx_EN = 1'b0;
        send(8'hFF, {G2, G2, G0, G1}, 4752);
        wait_idle(6000);
        Rx_EN = 1'b1;

        // Transmitter disabled mid start bit: frame aborts, display untouched
        send(8'h55, {G2, G2, G0, G1}, 101);
        repeat (100) @(negedge clk1);
        Tx_EN = 1'b0;
        @(negedge clk1);
        check("tx_en_drop busy", {31'd0, Tx_BUSY}, 0);
        check("tx_en_drop line", {31'd0, dut.line}, 1);
        Tx_EN = 1'b1;
        repeat (300) @(negedge clk1);

        // Stop bit forced low -> framing error shows dashes
        send(8'h1B, {GD, GD, GD, GD}, 4752);
        repeat (4399) @(negedge clk1);
        force dut.line = 1'b0;
        repeat (250) @(negedge clk1);
        release dut.line;
        wait_idle(6000);

        // Good frame clears the error: 0x1B -> 00 01 10 11
        send(8'h1B, {G0, G1, G2, G3}, 4752);
        wait_idle(6000);

        // 9600 baud: 0xE4 -> 11 10 01 00
        baud_select = 3'b011;
        repeat (3) @(negedge clk1);
        send(8'hE4, {G3, G2, G1, G0}, 57376);
        wait_idle(60000);

        repeat (10) @(negedge clk1);
        check("scoreboard drained", sb.size(), 0);
        check("frames seen", mon_done, 7);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
